// File: rtl/pifo_io_pkg.sv
// Shared types and helpers for the PIFO tree I/O arbiter.
//   op_e       : request operation encoding (push / pop)
//   calc_dw    : data width of a tree entry (metadata + payload)
//   rsp_tag_t  : one response-pipeline slot {valid, requester index}
//   rr_pick    : first set bit of a request vector at or after a pointer,
//                wrapping modulo the number of requesters
package pifo_io_pkg;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  // Upper bound on requesters handled by rr_pick and the response tag.
  localparam int MAX_REQ    = 16;
  localparam int MAX_REQ_IW = 4;

  function automatic int calc_dw(input int mtw, input int ptw);
    return mtw + ptw;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [MAX_REQ_IW-1:0] idx;
  } rsp_tag_t;

  // Returns {found, index}. The loop runs downward so the smallest offset
  // from the pointer is the last assignment and therefore wins.
  function automatic logic [MAX_REQ_IW:0] rr_pick(
    input logic [MAX_REQ-1:0]    req,
    input int                    n,
    input logic [MAX_REQ_IW-1:0] ptr
  );
    logic [MAX_REQ_IW:0] res;
    int                  j;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          res = {1'b1, j[MAX_REQ_IW-1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pifo_rr_arb.sv
// Round-robin picker: the request vector acts as the eligibility mask and
// the pointer marks the highest-priority position. Purely combinational so
// it can front any shared tree port.
//   req         : eligibility mask, one bit per requester
//   ptr         : requester with highest priority this cycle
//   grant_valid : at least one requester eligible
//   grant_idx   : winning requester
module pifo_rr_arb
  import pifo_io_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [MAX_REQ_IW:0] pick;

  always_comb begin
    pick        = rr_pick(MAX_REQ'(req), N, MAX_REQ_IW'(ptr));
    grant_valid = pick[MAX_REQ_IW];
    grant_idx   = IW'(pick[MAX_REQ_IW-1:0]);
  end

endmodule

// File: rtl/pifo_io_arbiter.sv
// Shares the single push/pop/tree-id port of the PIFO tree I/O block among
// NREQ requesters. One operation per cycle, round-robin. A tree whose task
// FIFO reports full is masked for BACKOFF cycles. Pop results come back
// POP_LAT cycles after issue and are steered to the issuing requester.
//   i_clk, i_arst        : clock, asynchronous active-high reset
//   i_req_*              : per-requester valid/op/tree/data (packed, req 0 in LSBs)
//   o_req_ready          : one-hot accept
//   o_rsp_valid/_data/_empty : pop response routed back to its requester
//   o_io_*               : tree id, push strobe/data, pop strobe to the I/O block
//   i_io_task_fail       : task FIFO full for o_io_tree_id (combinational)
//   i_io_pop_data        : pop result, valid POP_LAT cycles after o_io_pop
module pifo_io_arbiter
  import pifo_io_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int PTW      = 2,
  parameter  int MTW      = 3,
  parameter  int TREE_NUM = 6,
  parameter  int POP_LAT  = 3,
  parameter  int BACKOFF  = 4,
  localparam int DW       = calc_dw(MTW, PTW),
  localparam int TNB      = $clog2(TREE_NUM),
  localparam int BW       = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ-1:0]    i_req_op,
  input  logic [NREQ*TNB-1:0] i_req_tree_id,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]      o_rsp_data,
  output logic               o_rsp_empty,
  output logic [TNB-1:0]     o_io_tree_id,
  output logic               o_io_push,
  output logic [DW-1:0]      o_io_push_data,
  output logic               o_io_pop,
  input  logic               i_io_task_fail,
  input  logic [DW-1:0]      i_io_pop_data
);

  logic [IW-1:0]         rr_ptr_reg;
  logic [IW-1:0]         rr_ptr_next;
  logic [TREE_NUM-1:0]   bo_zero;
  logic [NREQ-1:0]       eligible;
  logic                  arb_valid;
  logic [IW-1:0]         arb_idx;
  logic                  win_valid;
  logic [TNB-1:0]        win_tree;
  logic [DW-1:0]         win_data;
  op_e                   win_op;
  logic                  issue;
  logic                  fail;
  rsp_tag_t              new_tag;
  rsp_tag_t [POP_LAT-1:0] tag_reg;
  rsp_tag_t              tail;

  genvar gi;

  // Tree ids beyond TREE_NUM have no backoff counter and are never masked.
  for (gi = 0; gi < NREQ; gi++) begin : g_elig
    logic [TNB-1:0] tid;
    assign tid          = i_req_tree_id[gi*TNB +: TNB];
    assign eligible[gi] = i_req_valid[gi] && ((int'(tid) >= TREE_NUM) || bo_zero[tid]);
  end

  pifo_rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr_reg),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // While reset is held the port stays quiet even if requests are pending.
  always_comb begin
    win_valid = arb_valid && !i_arst;
    win_tree  = '0;
    win_data  = '0;
    win_op    = OP_PUSH;
    if (win_valid) begin
      win_tree = i_req_tree_id[arb_idx*TNB +: TNB];
      win_data = i_req_data[arb_idx*DW +: DW];
      win_op   = op_e'(i_req_op[arb_idx]);
    end
  end

  assign fail  = win_valid && i_io_task_fail;
  assign issue = win_valid && !i_io_task_fail;

  assign o_io_tree_id   = win_tree;
  assign o_io_push_data = win_data;
  assign o_io_push      = issue && (win_op == OP_PUSH);
  assign o_io_pop       = issue && (win_op == OP_POP);
  assign o_req_ready    = issue ? (NREQ'(1) << arb_idx) : '0;

  // The pointer moves past the winner even on a task-fail, so a requester
  // stuck on a full tree cannot hold priority over everyone else.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (win_valid) begin
      rr_ptr_next = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Per-tree backoff: a reload wins over the countdown in the same cycle.
  for (gi = 0; gi < TREE_NUM; gi++) begin : g_bo
    logic [BW-1:0] cnt_reg;
    logic          reload;
    assign reload = fail && (win_tree == TNB'(gi));
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        cnt_reg <= '0;
      end else if (reload) begin
        cnt_reg <= BW'(BACKOFF);
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - BW'(1);
      end
    end
    assign bo_zero[gi] = (cnt_reg == '0);
  end

  // Response tags march one stage per cycle; the tail lines up with the
  // cycle the I/O block presents the pop data.
  assign new_tag = '{valid: o_io_pop, idx: MAX_REQ_IW'(arb_idx)};

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      tag_reg <= '0;
    end else begin
      tag_reg[0] <= new_tag;
      for (int k = 1; k < POP_LAT; k++) begin
        tag_reg[k] <= tag_reg[k-1];
      end
    end
  end

  assign tail = tag_reg[POP_LAT-1];

  for (gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign o_rsp_valid[gi] = tail.valid && (tail.idx == MAX_REQ_IW'(gi));
  end

  assign o_rsp_data  = tail.valid ? i_io_pop_data : '0;
  assign o_rsp_empty = tail.valid && (&i_io_pop_data);

endmodule

// File: tb/tb_pifo_io_arbiter.sv
// Testbench for pifo_io_arbiter: directed scenarios followed by a randomized
// run checked against a cycle-level behavioural model of the arbiter.
module tb_pifo_io_arbiter;

  localparam int NREQ     = 4;
  localparam int PTW      = 2;
  localparam int MTW      = 3;
  localparam int TREE_NUM = 6;
  localparam int POP_LAT  = 3;
  localparam int BACKOFF  = 4;
  localparam int DW       = MTW + PTW;
  localparam int TNB      = 3;

  logic                clk = 1'b0;
  logic                arst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_op;
  logic [NREQ*TNB-1:0] req_tree;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_empty;
  logic [TNB-1:0]      io_tree_id;
  logic                io_push;
  logic [DW-1:0]       io_push_data;
  logic                io_pop;
  logic                task_fail;
  logic [DW-1:0]       pop_data;
  logic [TREE_NUM-1:0] fail_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Task-full indication depends only on the presented tree id.
  always_comb task_fail = (int'(io_tree_id) < TREE_NUM) ? fail_mask[io_tree_id] : 1'b0;

  pifo_io_arbiter #(
    .NREQ(NREQ), .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM),
    .POP_LAT(POP_LAT), .BACKOFF(BACKOFF)
  ) dut (
    .i_clk          (clk),
    .i_arst         (arst),
    .i_req_valid    (req_valid),
    .i_req_op       (req_op),
    .i_req_tree_id  (req_tree),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_empty    (rsp_empty),
    .o_io_tree_id   (io_tree_id),
    .o_io_push      (io_push),
    .o_io_push_data (io_push_data),
    .o_io_pop       (io_pop),
    .i_io_task_fail (task_fail),
    .i_io_pop_data  (pop_data)
  );

  task automatic set_req(input int i, input bit v, input bit op, input int tree, input int data);
    req_valid[i]          = v;
    req_op[i]             = op;
    req_tree[i*TNB +: TNB] = TNB'(tree);
    req_data[i*DW +: DW]  = DW'(data);
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_op    = '0;
    req_tree  = '0;
    req_data  = '0;
    fail_mask = '0;
    pop_data  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    arst = 1'b1;
    next_cycle();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    arst = 1'b1;
    set_req(0, 1'b1, 1'b0, 2, 5);
    @(negedge clk);
    checks++;
    if ({req_ready, io_push, io_pop, io_tree_id, io_push_data, rsp_valid, rsp_data, rsp_empty} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b push=%b pop=%b tree=%0d data=%0d rsp=%b required all zero",
               req_ready, io_push, io_pop, io_tree_id, io_push_data, rsp_valid);
    end
    next_cycle();
    arst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || io_push !== 1'b0 || io_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ready=%b rsp=%b push=%b pop=%b required 0", req_ready, rsp_valid, io_push, io_pop);
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 2, 3 + 7 * i);
    for (int k = 0; k < 8; k++) begin
      logic [NREQ-1:0] exp_ready;
      logic [DW-1:0]   exp_data;
      @(negedge clk);
      exp_ready = NREQ'(1) << (k % NREQ);
      exp_data  = DW'(3 + 7 * (k % NREQ));
      checks++;
      if (req_ready !== exp_ready || io_push !== 1'b1 || io_pop !== 1'b0 ||
          io_tree_id !== TNB'(2) || io_push_data !== exp_data) begin
        errors++;
        $display("FAIL rr_order k=%0d ready=%b req=%b push=%b pop=%b tree=%0d data=%0d req_data=%0d",
                 k, req_ready, exp_ready, io_push, io_pop, io_tree_id, io_push_data, exp_data);
      end
      $display("rr k=%0d ready=%b", k, req_ready);
      next_cycle();
    end
  endtask

  task automatic test_backoff();
    do_reset();
    fail_mask = 6'b001000;
    set_req(1, 1'b1, 1'b0, 3, 9);
    set_req(2, 1'b1, 1'b0, 0, 21);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || io_push !== 1'b0 || io_tree_id !== TNB'(3)) begin
      errors++;
      $display("FAIL bo_fail ready=%b push=%b tree=%0d required 0000/0/3", req_ready, io_push, io_tree_id);
    end
    next_cycle();
    fail_mask = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || io_push !== 1'b1 || io_tree_id !== TNB'(0) || io_push_data !== DW'(21)) begin
      errors++;
      $display("FAIL bo_other ready=%b push=%b tree=%0d data=%0d required 0100/1/0/21",
               req_ready, io_push, io_tree_id, io_push_data);
    end
    next_cycle();
    set_req(2, 1'b0, 1'b0, 0, 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || io_push !== 1'b0 || io_tree_id !== TNB'(0)) begin
        errors++;
        $display("FAIL bo_masked c=%0d ready=%b push=%b tree=%0d required 0000/0/0", c, req_ready, io_push, io_tree_id);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || io_push !== 1'b1 || io_tree_id !== TNB'(3) || io_push_data !== DW'(9)) begin
      errors++;
      $display("FAIL bo_retry ready=%b push=%b tree=%0d data=%0d required 0010/1/3/9",
               req_ready, io_push, io_tree_id, io_push_data);
    end
    $display("backoff retry ready=%b", req_ready);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_pop_routing();
    do_reset();
    set_req(3, 1'b1, 1'b1, 1, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000 || io_pop !== 1'b1 || io_push !== 1'b0) begin
      errors++;
      $display("FAIL pop_issue3 ready=%b pop=%b push=%b required 1000/1/0", req_ready, io_pop, io_push);
    end
    next_cycle();
    set_req(3, 1'b0, 1'b0, 0, 0);
    set_req(0, 1'b1, 1'b1, 4, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || io_pop !== 1'b1 || io_tree_id !== TNB'(4)) begin
      errors++;
      $display("FAIL pop_issue0 ready=%b pop=%b tree=%0d required 0001/1/4", req_ready, io_pop, io_tree_id);
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL pop_early rsp=%b required 0000", rsp_valid);
    end
    next_cycle();
    pop_data = 5'h0A;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 5'h0A || rsp_empty !== 1'b0) begin
      errors++;
      $display("FAIL pop_rsp3 rsp=%b data=%h empty=%b required 1000/0a/0", rsp_valid, rsp_data, rsp_empty);
    end
    next_cycle();
    pop_data = 5'h15;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 5'h15 || rsp_empty !== 1'b0) begin
      errors++;
      $display("FAIL pop_rsp0 rsp=%b data=%h empty=%b required 0001/15/0", rsp_valid, rsp_data, rsp_empty);
    end
    next_cycle();
    pop_data = 5'h07;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL pop_after rsp=%b data=%h required 0000/00", rsp_valid, rsp_data);
    end
    $display("pop routing done");
  endtask

  task automatic test_empty_pop();
    do_reset();
    set_req(2, 1'b1, 1'b1, 5, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || io_pop !== 1'b1) begin
      errors++;
      $display("FAIL empty_issue ready=%b pop=%b required 0100/1", req_ready, io_pop);
    end
    next_cycle();
    set_req(2, 1'b0, 1'b0, 0, 0);
    next_cycle();
    next_cycle();
    pop_data = '1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_empty !== 1'b1 || rsp_data !== 5'h1F) begin
      errors++;
      $display("FAIL empty_rsp rsp=%b empty=%b data=%h required 0100/1/1f", rsp_valid, rsp_empty, rsp_data);
    end
    $display("empty pop rsp=%b empty=%b", rsp_valid, rsp_empty);
    next_cycle();
    pop_data = '0;
  endtask

  task automatic test_mixed();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1, 7);
    set_req(1, 1'b1, 1'b1, 5, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || io_push !== 1'b1 || io_pop !== 1'b0 || io_push_data !== DW'(7)) begin
      errors++;
      $display("FAIL mixed_push ready=%b push=%b pop=%b data=%0d required 0001/1/0/7",
               req_ready, io_push, io_pop, io_push_data);
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || io_push !== 1'b0 || io_pop !== 1'b1 || io_tree_id !== TNB'(5)) begin
      errors++;
      $display("FAIL mixed_pop ready=%b push=%b pop=%b tree=%0d required 0010/0/1/5",
               req_ready, io_push, io_pop, io_tree_id);
    end
    next_cycle();
    set_req(1, 1'b0, 1'b0, 0, 0);
    pop_data = 5'h0C;
    for (int c = 2; c <= 4; c++) begin
      logic [NREQ-1:0] exp_rsp;
      @(negedge clk);
      exp_rsp = (c == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if (rsp_valid !== exp_rsp || (c == 4 && rsp_data !== 5'h0C)) begin
        errors++;
        $display("FAIL mixed_rsp c=%0d rsp=%b data=%h required %b/0c", c, rsp_valid, rsp_data, exp_rsp);
      end
      next_cycle();
    end
    pop_data = '0;
    $display("mixed ops done");
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_req(1, 1'b1, 1'b1, 2, 0);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 0, 0);
    set_req(2, 1'b1, 1'b1, 3, 0);
    next_cycle();
    set_req(2, 1'b0, 1'b0, 0, 0);
    arst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, io_push, io_pop, io_tree_id, io_push_data, rsp_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset_out ready=%b push=%b pop=%b tree=%0d rsp=%b required all zero",
               req_ready, io_push, io_pop, io_tree_id, rsp_valid);
    end
    next_cycle();
    arst = 1'b0;
    pop_data = 5'h11;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 0, i);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL mid_reset_ptr ready=%b rsp=%b required 0001/0000", req_ready, rsp_valid);
    end
    next_cycle();
    clear_inputs();
    pop_data = 5'h12;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL mid_reset_rsp c=%0d rsp=%b required 0000", c, rsp_valid);
      end
      next_cycle();
    end
    $display("reset midstream done");
  endtask

  task automatic test_random();
    int          bo[TREE_NUM];
    int          rr;
    int          q_due[$];
    int          q_idx[$];
    bit          acc[NREQ];
    do_reset();
    rr = 0;
    for (int t = 0; t < TREE_NUM; t++) bo[t] = 0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int              win;
      int              win_tree;
      bit              mfail;
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rsp;
      logic            exp_push;
      logic            exp_pop;
      logic [TNB-1:0]  exp_tree;
      logic [DW-1:0]   exp_data;
      logic [DW-1:0]   exp_rdata;
      logic            exp_empty;

      // Drive: accepted requests end; pending ones are held or rarely withdrawn.
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
          acc[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(99) < 5) begin
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && $urandom_range(99) < 50) begin
          set_req(i, 1'b1, 1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(31)));
        end
      end
      if ($urandom_range(99) < 20) fail_mask = TREE_NUM'($urandom);
      pop_data = DW'($urandom);
      @(negedge clk);

      // Reference: scan from rr for the first valid requester on an unmasked tree.
      win = -1;
      win_tree = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        int t;
        j = (rr + k) % NREQ;
        t = int'(req_tree[j*TNB +: TNB]);
        if (win < 0 && req_valid[j] && (t >= TREE_NUM || bo[t] == 0)) begin
          win = j;
          win_tree = t;
        end
      end
      exp_ready = '0; exp_push = 1'b0; exp_pop = 1'b0; exp_tree = '0; exp_data = '0; mfail = 1'b0;
      if (win >= 0) begin
        exp_tree = TNB'(win_tree);
        exp_data = req_data[win*DW +: DW];
        mfail = (win_tree < TREE_NUM) && fail_mask[win_tree];
        if (!mfail) begin
          exp_ready = NREQ'(1) << win;
          exp_push = !req_op[win];
          exp_pop = req_op[win];
        end
      end
      exp_rsp = '0; exp_rdata = '0; exp_empty = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        exp_rsp = NREQ'(1) << q_idx[0];
        exp_rdata = pop_data;
        exp_empty = (pop_data == 5'h1F);
        void'(q_due.pop_front());
        void'(q_idx.pop_front());
      end

      checks++;
      if (req_ready !== exp_ready || io_push !== exp_push || io_pop !== exp_pop ||
          io_tree_id !== exp_tree || io_push_data !== exp_data) begin
        errors++;
        $display("FAIL rand_issue cyc=%0d ready=%b/%b push=%b/%b pop=%b/%b tree=%0d/%0d data=%0d/%0d",
                 cyc, req_ready, exp_ready, io_push, exp_push, io_pop, exp_pop,
                 io_tree_id, exp_tree, io_push_data, exp_data);
      end
      checks++;
      if (rsp_valid !== exp_rsp || rsp_data !== exp_rdata || rsp_empty !== exp_empty) begin
        errors++;
        $display("FAIL rand_rsp cyc=%0d rsp=%b/%b data=%h/%h empty=%b/%b",
                 cyc, rsp_valid, exp_rsp, rsp_data, exp_rdata, rsp_empty, exp_empty);
      end
      $display("rand cyc=%0d win=%0d fail=%0d ready=%b rsp=%b", cyc, win, mfail, req_ready, rsp_valid);

      // Advance the reference state to match the coming clock edge.
      for (int t = 0; t < TREE_NUM; t++) begin
        if (win >= 0 && mfail && t == win_tree) bo[t] = BACKOFF;
        else if (bo[t] > 0) bo[t] = bo[t] - 1;
      end
      if (win >= 0) rr = (win + 1) % NREQ;
      if (exp_pop) begin
        q_due.push_back(cyc + POP_LAT);
        q_idx.push_back(win);
      end
      if (win >= 0 && !mfail) acc[win] = 1'b1;
      next_cycle();
    end
  endtask

  initial begin
    arst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backoff();
    test_pop_routing();
    test_empty_pop();
    test_mixed();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
